// File: rtl/mem_access_unit_pkg.sv
// Shared types and op-class helpers for the M-stage memory access unit.
package mem_access_unit_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_LWL  = 4'd6,
    OP_LWR  = 4'd7,
    OP_SB   = 4'd8,
    OP_SH   = 4'd9,
    OP_SW   = 4'd10,
    OP_SWL  = 4'd11,
    OP_SWR  = 4'd12
  } mem_op_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2
  } msize_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } mau_state_t;

  function automatic logic is_load(input mem_op_t op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR: is_load = 1'b1;
      default: is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input mem_op_t op);
    case (op)
      OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR: is_store = 1'b1;
      default: is_store = 1'b0;
    endcase
  endfunction

  function automatic logic is_unaligned_op(input mem_op_t op);
    case (op)
      OP_LWL, OP_LWR, OP_SWL, OP_SWR: is_unaligned_op = 1'b1;
      default: is_unaligned_op = 1'b0;
    endcase
  endfunction

  function automatic msize_t op_size(input mem_op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = MSIZE1;
      OP_LH, OP_LHU, OP_SH: op_size = MSIZE2;
      default: op_size = MSIZE4;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane alignment: store strobe/data shifting and load extract/extend/merge.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  mem_op_t     st_op,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_strobe,
  output logic [31:0] st_data,
  input  mem_op_t     ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_data,
  input  logic [31:0] ld_old,
  output logic [31:0] ld_result
);

  // Store lane placement
  always_comb begin
    st_strobe = 4'h0;
    st_data   = 32'h0;
    case (st_op)
      OP_SB: begin
        st_strobe = 4'b0001 << st_off;
        st_data   = st_wdata << {st_off, 3'b000};
      end
      OP_SH: begin
        st_strobe = 4'b0011 << st_off;
        st_data   = st_wdata << {st_off, 3'b000};
      end
      OP_SW: begin
        st_strobe = 4'hF;
        st_data   = st_wdata;
      end
      OP_SWL: begin
        st_strobe = 4'hF >> (2'd3 - st_off);
        st_data   = st_wdata >> {(2'd3 - st_off), 3'b000};
      end
      OP_SWR: begin
        st_strobe = 4'hF << st_off;
        st_data   = st_wdata << {st_off, 3'b000};
      end
      default: begin
        st_strobe = 4'h0;
        st_data   = 32'h0;
      end
    endcase
  end

  logic [31:0] down_s;
  logic [15:0] half_s;
  logic [5:0]  lwl_sh_s;

  // Load extraction; LWL keep-mask shift reaches 32 at offset 3 and clears
  always_comb begin
    down_s    = ld_data >> {ld_off, 3'b000};
    half_s    = ld_off[1] ? ld_data[31:16] : ld_data[15:0];
    lwl_sh_s  = {({1'b0, ld_off} + 3'd1), 3'b000};
    ld_result = 32'h0;
    case (ld_op)
      OP_LB:  ld_result = {{24{down_s[7]}}, down_s[7:0]};
      OP_LBU: ld_result = {24'h0, down_s[7:0]};
      OP_LH:  ld_result = {{16{half_s[15]}}, half_s};
      OP_LHU: ld_result = {16'h0, half_s};
      OP_LW:  ld_result = ld_data;
      OP_LWL: ld_result = (ld_data << {(2'd3 - ld_off), 3'b000})
                        | (ld_old & (32'hFFFF_FFFF >> lwl_sh_s));
      OP_LWR: ld_result = down_s | (ld_old & ~(32'hFFFF_FFFF >> {ld_off, 3'b000}));
      default: ld_result = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage dbus transaction owner: alignment checks, request FSM, flush draining, stall.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter bit UNALIGNED_EN = 1'b1,
  parameter bit CHECK_ALIGN  = 1'b1
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  mem_op_t           in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [31:0]       in_old,
  input  logic              flush,
  output logic              stall,
  output logic              out_valid,
  output logic [31:0]       out_rdata,
  output logic              out_exc_adel,
  output logic              out_exc_ades,
  output logic              out_exc_ri,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output msize_t            dreq_size,
  output logic [3:0]        dreq_strobe,
  output logic [31:0]       dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [31:0]       dresp_data
);

  mau_state_t  state;
  logic        flushed;
  logic [31:0] rdata_q;
  mem_op_t     op_q;
  logic [1:0]  off_q;
  logic [31:0] old_q;

  logic        req_s, unsup_s, misal_s, reject_s, launch_s, idle_exc_s;
  logic [3:0]  st_strobe_s;
  logic [31:0] st_data_s, ld_result_s;

  mem_lane_align u_align (
    .st_op     (in_op),
    .st_off    (in_addr[1:0]),
    .st_wdata  (in_wdata),
    .st_strobe (st_strobe_s),
    .st_data   (st_data_s),
    .ld_op     (op_q),
    .ld_off    (off_q),
    .ld_data   (dresp_data),
    .ld_old    (old_q),
    .ld_result (ld_result_s)
  );

  // Decode of the op presented by the M stage
  always_comb begin
    req_s   = in_valid && (in_op != OP_NONE) && !flush && !reset;
    unsup_s = is_unaligned_op(in_op) && !UNALIGNED_EN;
    misal_s = 1'b0;
    if (CHECK_ALIGN) begin
      case (in_op)
        OP_LH, OP_LHU, OP_SH: misal_s = in_addr[0];
        OP_LW, OP_SW:         misal_s = |in_addr[1:0];
        default:              misal_s = 1'b0;
      endcase
    end else begin
      misal_s = 1'b0;
    end
    reject_s   = unsup_s || misal_s;
    idle_exc_s = (state == S_IDLE) && req_s && reject_s;
    launch_s   = (state == S_IDLE) && req_s && !reject_s;
  end

  // Result, exception and stall outputs
  always_comb begin
    out_valid    = idle_exc_s || ((state == S_DONE) && !flushed && !flush);
    out_rdata    = (state == S_DONE) ? rdata_q : 32'h0;
    out_exc_adel = idle_exc_s && !unsup_s && is_load(in_op);
    out_exc_ades = idle_exc_s && !unsup_s && is_store(in_op);
    out_exc_ri   = idle_exc_s && unsup_s;
    dreq_valid   = (state == S_ADDR);
    // Once the in-flight op is squashed, only a newly arrived op holds the pipe
    case (state)
      S_IDLE:         stall = launch_s;
      S_ADDR, S_DATA: stall = (flushed || flush) ? req_s : 1'b1;
      S_DONE:         stall = flushed && req_s;
      default:        stall = 1'b0;
    endcase
  end

  // Request FSM with registered bus fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      flushed     <= 1'b0;
      rdata_q     <= 32'h0;
      op_q        <= OP_NONE;
      off_q       <= 2'd0;
      old_q       <= 32'h0;
      dreq_addr   <= '0;
      dreq_size   <= MSIZE1;
      dreq_strobe <= 4'h0;
      dreq_data   <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch_s) begin
            state       <= S_ADDR;
            op_q        <= in_op;
            off_q       <= in_addr[1:0];
            old_q       <= in_old;
            dreq_addr   <= is_unaligned_op(in_op) ? {in_addr[ADDR_W-1:2], 2'b00} : in_addr;
            dreq_size   <= op_size(in_op);
            dreq_strobe <= st_strobe_s;
            dreq_data   <= st_data_s;
          end
        end
        S_ADDR: begin
          if (flush) flushed <= 1'b1;
          if (dresp_addr_ok) begin
            if (dresp_data_ok) begin
              rdata_q <= ld_result_s;
              state   <= S_DONE;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (flush) flushed <= 1'b1;
          if (dresp_data_ok) begin
            rdata_q <= ld_result_s;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          flushed <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed-vector bench for mem_access_unit: table of single ops plus multi-cycle sequences.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, flush;
  mem_op_t     in_op;
  logic [31:0] in_addr, in_wdata, in_old;
  logic        stall, out_valid, out_exc_adel, out_exc_ades, out_exc_ri;
  logic [31:0] out_rdata;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  msize_t      dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [31:0] dresp_data;

  int n_chk = 0;
  int n_fail = 0;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_old(in_old), .flush(flush), .stall(stall),
    .out_valid(out_valid), .out_rdata(out_rdata), .out_exc_adel(out_exc_adel),
    .out_exc_ades(out_exc_ades), .out_exc_ri(out_exc_ri), .dreq_valid(dreq_valid),
    .dreq_addr(dreq_addr), .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
    .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    mem_op_t     op;
    logic [31:0] addr, wdata, old, bus;
    logic [31:0] e_addr;
    msize_t      e_size;
    logic [3:0]  e_strb;
    logic [31:0] e_data, e_res;
    logic [2:0]  e_exc;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put_op(input mem_op_t op, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] od);
    in_valid = 1'b1; in_op = op; in_addr = a; in_wdata = wd; in_old = od;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    cyc();
    put_op(v.op, v.addr, v.wdata, v.old);
    @(negedge clk);
    if (v.e_exc != 3'b000) begin
      chk($sformatf("v%0d exc_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d exc_flags", i), 32'({out_exc_adel, out_exc_ades, out_exc_ri}), 32'(v.e_exc));
      chk($sformatf("v%0d exc_stall", i), 32'(stall), 32'd0);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d exc_noreq", i), 32'(dreq_valid), 32'd0);
    end else begin
      chk($sformatf("v%0d launch_stall", i), 32'(stall), 32'd1);
      cyc();
      dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = v.bus;
      @(negedge clk);
      chk($sformatf("v%0d dreq_valid", i), 32'(dreq_valid), 32'd1);
      chk($sformatf("v%0d dreq_addr", i), dreq_addr, v.e_addr);
      chk($sformatf("v%0d dreq_size", i), 32'(dreq_size), 32'(v.e_size));
      chk($sformatf("v%0d dreq_strobe", i), 32'(dreq_strobe), 32'(v.e_strb));
      chk($sformatf("v%0d dreq_data", i), dreq_data, v.e_data);
      cyc();
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'h0;
      @(negedge clk);
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d out_rdata", i), out_rdata, v.e_res);
      chk($sformatf("v%0d done_stall", i), 32'(stall), 32'd0);
      cyc();
      in_valid = 1'b0;
    end
  endtask

  initial begin
    int stall_cnt;
    vecs[0]  = '{OP_LB,  32'h1003, 32'h0, 32'h0, 32'h80AABBCC, 32'h1003, MSIZE1, 4'h0, 32'h0, 32'hFFFFFF80, 3'b000};
    vecs[1]  = '{OP_LBU, 32'h1001, 32'h0, 32'h0, 32'h80AABBCC, 32'h1001, MSIZE1, 4'h0, 32'h0, 32'h000000BB, 3'b000};
    vecs[2]  = '{OP_LH,  32'h1002, 32'h0, 32'h0, 32'h80AABBCC, 32'h1002, MSIZE2, 4'h0, 32'h0, 32'hFFFF80AA, 3'b000};
    vecs[3]  = '{OP_LHU, 32'h1000, 32'h0, 32'h0, 32'h80AABBCC, 32'h1000, MSIZE2, 4'h0, 32'h0, 32'h0000BBCC, 3'b000};
    vecs[4]  = '{OP_LW,  32'h1004, 32'h0, 32'h0, 32'hDEADBEEF, 32'h1004, MSIZE4, 4'h0, 32'h0, 32'hDEADBEEF, 3'b000};
    vecs[5]  = '{OP_LWL, 32'h4001, 32'h0, 32'hAABBCCDD, 32'h11223344, 32'h4000, MSIZE4, 4'h0, 32'h0, 32'h3344CCDD, 3'b000};
    vecs[6]  = '{OP_LWR, 32'h4001, 32'h0, 32'hAABBCCDD, 32'h11223344, 32'h4000, MSIZE4, 4'h0, 32'h0, 32'hAA112233, 3'b000};
    vecs[7]  = '{OP_LWL, 32'h4003, 32'h0, 32'hAABBCCDD, 32'h11223344, 32'h4000, MSIZE4, 4'h0, 32'h0, 32'h11223344, 3'b000};
    vecs[8]  = '{OP_LWR, 32'h4000, 32'h0, 32'hAABBCCDD, 32'h11223344, 32'h4000, MSIZE4, 4'h0, 32'h0, 32'h11223344, 3'b000};
    vecs[9]  = '{OP_SB,  32'h2001, 32'h123456AB, 32'h0, 32'h0, 32'h2001, MSIZE1, 4'h2, 32'h3456AB00, 32'h0, 3'b000};
    vecs[10] = '{OP_SH,  32'h2002, 32'h1234ABCD, 32'h0, 32'h0, 32'h2002, MSIZE2, 4'hC, 32'hABCD0000, 32'h0, 3'b000};
    vecs[11] = '{OP_SW,  32'h2004, 32'hCAFEF00D, 32'h0, 32'h0, 32'h2004, MSIZE4, 4'hF, 32'hCAFEF00D, 32'h0, 3'b000};
    vecs[12] = '{OP_SWL, 32'h2001, 32'h11223344, 32'h0, 32'h0, 32'h2000, MSIZE4, 4'h3, 32'h00001122, 32'h0, 3'b000};
    vecs[13] = '{OP_SWR, 32'h2001, 32'h11223344, 32'h0, 32'h0, 32'h2000, MSIZE4, 4'hE, 32'h22334400, 32'h0, 3'b000};
    vecs[14] = '{OP_LW,  32'h3001, 32'h0, 32'h0, 32'h0, 32'h0, MSIZE1, 4'h0, 32'h0, 32'h0, 3'b100};
    vecs[15] = '{OP_SH,  32'h2001, 32'h0, 32'h0, 32'h0, 32'h0, MSIZE1, 4'h0, 32'h0, 32'h0, 3'b010};
    vecs[16] = '{OP_LH,  32'h1003, 32'h0, 32'h0, 32'h0, 32'h0, MSIZE1, 4'h0, 32'h0, 32'h0, 3'b100};

    reset = 1'b1; in_valid = 1'b0; in_op = OP_NONE; in_addr = 32'h0; in_wdata = 32'h0;
    in_old = 32'h0; flush = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'h0;
    repeat (2) cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst dreq_valid", 32'(dreq_valid), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_rdata", out_rdata, 32'h0);
    chk("rst dreq_strobe", 32'(dreq_strobe), 32'h0);

    for (int i = 0; i < 17; i++) run_vec(i);

    // LB with data_ok two cycles after addr_ok: stall held for four cycles
    stall_cnt = 0;
    cyc(); put_op(OP_LB, 32'h1003, 32'h0, 32'h0);
    @(negedge clk); stall_cnt += int'(stall);
    cyc(); dresp_addr_ok = 1'b1;
    @(negedge clk); stall_cnt += int'(stall);
    cyc(); dresp_addr_ok = 1'b0;
    @(negedge clk); stall_cnt += int'(stall);
    cyc(); dresp_data_ok = 1'b1; dresp_data = 32'h80AABBCC;
    @(negedge clk); stall_cnt += int'(stall);
    cyc(); dresp_data_ok = 1'b0;
    @(negedge clk); stall_cnt += int'(stall);
    chk("lat stall_cycles", 32'(stall_cnt), 32'd4);
    chk("lat out_valid", 32'(out_valid), 32'd1);
    chk("lat out_rdata", out_rdata, 32'hFFFFFF80);
    cyc(); in_valid = 1'b0;

    // SH request fields stable while addr_ok withheld
    cyc(); put_op(OP_SH, 32'h2002, 32'h1234ABCD, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc(); in_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk($sformatf("hold%0d valid", k), 32'(dreq_valid), 32'd1);
      chk($sformatf("hold%0d strobe", k), 32'(dreq_strobe), 32'hC);
      chk($sformatf("hold%0d data", k), dreq_data, 32'hABCD0000);
      chk($sformatf("hold%0d size", k), 32'(dreq_size), 32'(MSIZE2));
      chk($sformatf("hold%0d stall", k), 32'(stall), 32'd1);
    end
    cyc(); dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
    cyc(); dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    @(negedge clk);
    chk("hold done_valid", 32'(out_valid), 32'd1);
    chk("hold done_rdata", out_rdata, 32'h0);
    cyc(); in_valid = 1'b0;

    // Flush in ADDR: request kept until addr_ok, op drained silently, next SW waits
    cyc(); put_op(OP_LW, 32'h5000, 32'h0, 32'h0);
    cyc(); flush = 1'b1;
    @(negedge clk);
    chk("fl stall_drop", 32'(stall), 32'd0);
    chk("fl dreq_kept", 32'(dreq_valid), 32'd1);
    chk("fl out_valid0", 32'(out_valid), 32'd0);
    cyc(); flush = 1'b0; put_op(OP_SW, 32'h6000, 32'h55AA55AA, 32'h0);
    @(negedge clk);
    chk("fl dreq_kept2", 32'(dreq_valid), 32'd1);
    chk("fl dreq_addr_old", dreq_addr, 32'h5000);
    chk("fl new_waits", 32'(stall), 32'd1);
    cyc(); dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'h12345678;
    @(negedge clk);
    chk("fl dreq_until_ok", 32'(dreq_valid), 32'd1);
    cyc(); dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    @(negedge clk);
    chk("fl done_silent", 32'(out_valid), 32'd0);
    chk("fl done_stall", 32'(stall), 32'd1);
    cyc();
    @(negedge clk);
    chk("fl sw_launch_stall", 32'(stall), 32'd1);
    cyc(); dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
    @(negedge clk);
    chk("fl sw_addr", dreq_addr, 32'h6000);
    chk("fl sw_strobe", 32'(dreq_strobe), 32'hF);
    chk("fl sw_data", dreq_data, 32'h55AA55AA);
    cyc(); dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    @(negedge clk);
    chk("fl sw_done", 32'(out_valid), 32'd1);
    cyc(); in_valid = 1'b0;

    // Flush in IDLE: nothing issued
    cyc(); put_op(OP_LW, 32'h5004, 32'h0, 32'h0); flush = 1'b1;
    @(negedge clk);
    chk("fi out_valid", 32'(out_valid), 32'd0);
    chk("fi stall", 32'(stall), 32'd0);
    cyc(); in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("fi no_req", 32'(dreq_valid), 32'd0);

    // Asynchronous reset in the middle of DATA
    cyc(); put_op(OP_LW, 32'h7000, 32'h0, 32'h0);
    cyc(); dresp_addr_ok = 1'b1;
    cyc(); dresp_addr_ok = 1'b0;
    @(negedge clk);
    chk("rd in_data_stall", 32'(stall), 32'd1);
    #2; reset = 1'b1; #1;
    chk("rd dreq_valid", 32'(dreq_valid), 32'd0);
    chk("rd stall", 32'(stall), 32'd0);
    chk("rd out_valid", 32'(out_valid), 32'd0);
    cyc(); reset = 1'b0; in_valid = 1'b0;
    run_vec(11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
